// File: rtl/cnn_pkg.sv
// Shared CNN constants, FSM state type and accumulator saturation helper.
package cnn_pkg;

  localparam int DATA_W   = 32;
  localparam int ACC_W    = 72;
  localparam int IN_SIDE  = 8;
  localparam int OUT_SIDE = 6;
  localparam int K_SIDE   = 3;
  localparam int IN_PIX   = IN_SIDE * IN_SIDE;
  localparam int OUT_PIX  = OUT_SIDE * OUT_SIDE;
  localparam int K_TAPS   = K_SIDE * K_SIDE;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    MAC,
    WRITE,
    DONE
  } conv_state_t;

  // In range only when every bit above the DATA_W sign bit matches it.
  function automatic logic signed [DATA_W-1:0] sat_to_data(input logic signed [ACC_W-1:0] v);
    logic [ACC_W-DATA_W:0] upper;
    upper = v[ACC_W-1:DATA_W-1];
    if (upper == '0 || upper == '1)
      return v[DATA_W-1:0];
    else if (v[ACC_W-1])
      return {1'b1, {(DATA_W-1){1'b0}}};
    else
      return {1'b0, {(DATA_W-1){1'b1}}};
  endfunction

endpackage

// File: rtl/mac_unit.sv
// Single signed multiply-accumulate: clr loads init, en adds a*b.
module mac_unit #(
  parameter int DATA_W = cnn_pkg::DATA_W,
  parameter int ACC_W  = cnn_pkg::ACC_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     en,
  input  logic signed [ACC_W-1:0]  init,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [ACC_W-1:0]  acc
);
  import cnn_pkg::*;

  logic signed [2*DATA_W-1:0] a_ext;
  logic signed [2*DATA_W-1:0] b_ext;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    prod_ext;

  assign a_ext    = {{DATA_W{a[DATA_W-1]}}, a};
  assign b_ext    = {{DATA_W{b[DATA_W-1]}}, b};
  assign prod     = a_ext * b_ext;
  assign prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};

  always_ff @(posedge clk) begin
    if (rst)
      acc <= '0;
    else if (clr)
      acc <= init;
    else if (en)
      acc <= acc + prod_ext;
  end

endmodule

// File: rtl/conv3x3_layer.sv
// 8x8 -> 6x6 valid 3x3 convolution with bias, one time-multiplexed MAC.
// Build option: define CONV_RELU_EN to clamp negative outputs to zero.
module conv3x3_layer #(
  parameter int IN_W   = cnn_pkg::IN_SIDE,
  parameter int IN_H   = cnn_pkg::IN_SIDE,
  parameter int K      = cnn_pkg::K_SIDE,
  parameter int DATA_W = cnn_pkg::DATA_W,
  parameter int ACC_W  = cnn_pkg::ACC_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic signed [DATA_W-1:0] input_fm  [IN_W*IN_H],
  input  logic signed [DATA_W-1:0] kernel    [K*K],
  input  logic signed [DATA_W-1:0] bias,
  output logic                     busy,
  output logic                     done,
  output logic signed [DATA_W-1:0] output_fm [(IN_W-K+1)*(IN_H-K+1)]
);
  import cnn_pkg::*;

  localparam int N_OUT = (IN_W-K+1) * (IN_H-K+1);

  conv_state_t state;
  logic [2:0] row;
  logic [2:0] col;
  logic [3:0] k;
  logic [5:0] out_idx;

  logic signed [DATA_W-1:0] in_reg   [IN_W*IN_H];
  logic signed [DATA_W-1:0] kern_reg [K*K];
  logic signed [DATA_W-1:0] bias_reg;

  logic [1:0] k_row;
  logic [1:0] k_col;
  logic [2:0] pix_row;
  logic [2:0] pix_col;
  logic [5:0] pix_addr;

  logic                    mac_clr;
  logic                    mac_en;
  logic signed [ACC_W-1:0] mac_init;
  logic signed [ACC_W-1:0] acc;
  logic signed [DATA_W-1:0] sat_val;
  logic signed [DATA_W-1:0] result;

  // Tap index -> kernel row/col offset without a divider.
  always_comb begin
    k_row = 2'd0;
    k_col = 2'd0;
    case (k)
      4'd1: k_col = 2'd1;
      4'd2: k_col = 2'd2;
      4'd3: k_row = 2'd1;
      4'd4: begin k_row = 2'd1; k_col = 2'd1; end
      4'd5: begin k_row = 2'd1; k_col = 2'd2; end
      4'd6: k_row = 2'd2;
      4'd7: begin k_row = 2'd2; k_col = 2'd1; end
      4'd8: begin k_row = 2'd2; k_col = 2'd2; end
      default: ;
    endcase
  end

  // Row and column stay below 8, so the pixel address is a plain bit concatenation.
  assign pix_row  = row + {1'b0, k_row};
  assign pix_col  = col + {1'b0, k_col};
  assign pix_addr = {pix_row, pix_col};

  assign mac_en   = (state == MAC);
  assign mac_clr  = (state == LOAD) || (state == WRITE);
  assign mac_init = (state == LOAD) ? {{(ACC_W-DATA_W){bias[DATA_W-1]}}, bias}
                                    : {{(ACC_W-DATA_W){bias_reg[DATA_W-1]}}, bias_reg};

  mac_unit #(
    .DATA_W(DATA_W),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk (clk),
    .rst (rst),
    .clr (mac_clr),
    .en  (mac_en),
    .init(mac_init),
    .a   (in_reg[pix_addr]),
    .b   (kern_reg[k]),
    .acc (acc)
  );

  assign sat_val = sat_to_data(acc);
`ifdef CONV_RELU_EN
  assign result = sat_val[DATA_W-1] ? '0 : sat_val;
`else
  assign result = sat_val;
`endif

  always_ff @(posedge clk) begin
    if (state == LOAD) begin
      in_reg   <= input_fm;
      kern_reg <= kernel;
      bias_reg <= bias;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      row     <= '0;
      col     <= '0;
      k       <= '0;
      out_idx <= '0;
      for (int i = 0; i < N_OUT; i++)
        output_fm[i] <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state   <= LOAD;
            busy    <= 1'b1;
            done    <= 1'b0;
            row     <= '0;
            col     <= '0;
            out_idx <= '0;
          end
        end
        LOAD: begin
          k     <= '0;
          state <= MAC;
        end
        MAC: begin
          if (k == 4'd8)
            state <= WRITE;
          else
            k <= k + 4'd1;
        end
        WRITE: begin
          output_fm[out_idx] <= result;
          k <= '0;
          if (col == 3'd5) begin
            col <= '0;
            row <= row + 3'd1;
          end else begin
            col <= col + 3'd1;
          end
          if (out_idx == 6'(N_OUT - 1)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            out_idx <= out_idx + 6'd1;
            state   <= MAC;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv3x3_layer.sv
// Directed table-driven bench for conv3x3_layer, plus reset and restart-ignore sequences.
module tb_conv3x3_layer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic signed [31:0] input_fm  [64];
  logic signed [31:0] kernel    [9];
  logic signed [31:0] bias;
  logic busy;
  logic done;
  logic signed [31:0] output_fm [36];

  int passCount = 0;
  int checkCount = 0;

  always #5 clk = ~clk;

  conv3x3_layer dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .input_fm (input_fm),
    .kernel   (kernel),
    .bias     (bias),
    .busy     (busy),
    .done     (done),
    .output_fm(output_fm)
  );

  typedef struct {
    string              name;
    bit                 rampIn;
    logic signed [31:0] inVal;
    bit                 centerK;
    logic signed [31:0] kVal;
    logic signed [31:0] biasVal;
    bit                 rampExp;
    longint             expVal;
  } vec_t;

  vec_t vecs [8];

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checkCount++;
    if (actual == expected)
      passCount++;
    else
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  function automatic longint expectedOut(input vec_t v, input int idx);
    longint e;
    if (v.rampExp)
      e = longint'((idx / 6 + 1) * 8 + (idx % 6 + 1)) + v.expVal;
    else
      e = v.expVal;
`ifdef CONV_RELU_EN
    if (e < 0) e = 0;
`endif
    return e;
  endfunction

  task automatic loadVector(input vec_t v);
    for (int i = 0; i < 64; i++)
      input_fm[i] = v.rampIn ? 32'(i) : v.inVal;
    for (int i = 0; i < 9; i++)
      kernel[i] = v.centerK ? ((i == 4) ? v.kVal : 32'sd0) : v.kVal;
    bias = v.biasVal;
  endtask

  // injectKind: 0 none, 1 reset before edge injectAt, 2 start pulse + input change before edge injectAt.
  task automatic runConv(input int injectAt, input int injectKind, output int doneCycle,
                         output bit busyEarly, output bit busyLate, output bit doneEarly,
                         output bit busyAtDone);
    doneCycle = -1;
    busyEarly = 1'b0;
    busyLate = 1'b0;
    doneEarly = 1'b1;
    busyAtDone = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      start = (injectKind == 2) && (c == injectAt);
      rst   = (injectKind == 1) && (c == injectAt);
      if (injectKind == 2 && c == injectAt) begin
        for (int i = 0; i < 64; i++) input_fm[i] = 32'sd7;
        for (int i = 0; i < 9; i++) kernel[i] = 32'sd3;
        bias = 32'sd1000;
      end
      @(posedge clk);
      #1;
      if (c == 1) begin
        busyEarly = busy;
        doneEarly = done;
      end
      if (c == 360) busyLate = busy;
      if (injectKind == 1 && c == injectAt) begin
        doneCycle = c;
        return;
      end
      if (done) begin
        doneCycle = c;
        busyAtDone = busy;
        return;
      end
    end
  endtask

  task automatic applyStimulus(input vec_t v, input int tag);
    int dc;
    bit be, bl, de, bd;
    loadVector(v);
    runConv(0, 0, dc, be, bl, de, bd);
    checkOutput($sformatf("%s done cycle", v.name), dc, 361);
    checkOutput($sformatf("%s busy after start", v.name), be, 1);
    checkOutput($sformatf("%s done cleared by start", v.name), de, 0);
    checkOutput($sformatf("%s busy before end", v.name), bl, 1);
    checkOutput($sformatf("%s busy at done", v.name), bd, 0);
    for (int i = 0; i < 36; i++)
      checkOutput($sformatf("%s out[%0d]", v.name, i), output_fm[i], expectedOut(v, i));
    if (tag < 0) $display("[TB] unreachable");
  endtask

  initial begin
    int dc;
    bit be, bl, de, bd;

    vecs[0] = '{"ones",     1'b0, 32'sd1,            1'b0, 32'sd1,       32'sd0,    1'b0, 64'sd9};
    vecs[1] = '{"ramp",     1'b1, 32'sd0,            1'b1, 32'sd1,       32'sd5,    1'b1, 64'sd5};
    vecs[2] = '{"pos_max",  1'b0, 32'sh7FFFFFFF,     1'b0, 32'sd1,       32'sd0,    1'b0, 64'sd2147483647};
    vecs[3] = '{"neg_min",  1'b0, 32'sh80000000,     1'b0, 32'sd1,       32'sd0,    1'b0, -64'sd2147483648};
    vecs[4] = '{"neg_k",    1'b0, 32'sd1,            1'b0, -32'sd1,      32'sd2,    1'b0, -64'sd7};
    vecs[5] = '{"mixed",    1'b0, 32'sd3,            1'b0, 32'sd2,       -32'sd100, 1'b0, -64'sd46};
    vecs[6] = '{"prod_sat", 1'b0, 32'sh00010000,     1'b0, 32'sh00010000, 32'sd0,   1'b0, 64'sd2147483647};
    vecs[7] = '{"nsum_sat", 1'b0, 32'sh7FFFFFFF,     1'b0, -32'sd1,      32'sd0,    1'b0, -64'sd2147483648};

    loadVector(vecs[0]);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("reset busy", busy, 0);
    checkOutput("reset done", done, 0);
    for (int i = 0; i < 36; i++)
      checkOutput($sformatf("reset out[%0d]", i), output_fm[i], 0);

    for (int v = 0; v < 8; v++)
      applyStimulus(vecs[v], v);

    // Mid-run reset at cycle 100: entries already written must clear.
    loadVector(vecs[0]);
    runConv(100, 1, dc, be, bl, de, bd);
    checkOutput("midreset edge", dc, 100);
    checkOutput("midreset busy", busy, 0);
    checkOutput("midreset done", done, 0);
    for (int i = 0; i < 36; i++)
      checkOutput($sformatf("midreset out[%0d]", i), output_fm[i], 0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(vecs[0], 100);

    // Start pulse and input change mid-run must not disturb the snapshot.
    loadVector(vecs[1]);
    runConv(50, 2, dc, be, bl, de, bd);
    checkOutput("restart ignored done cycle", dc, 361);
    checkOutput("restart ignored busy at done", bd, 0);
    for (int i = 0; i < 36; i++)
      checkOutput($sformatf("restart out[%0d]", i), output_fm[i], expectedOut(vecs[1], i));

    // Outputs hold while idle in DONE.
    repeat (5) @(posedge clk);
    #1;
    checkOutput("done held", done, 1);
    checkOutput("hold out[0]", output_fm[0], expectedOut(vecs[1], 0));
    checkOutput("hold out[35]", output_fm[35], expectedOut(vecs[1], 35));

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
